pe_ctx_sequencer: RTL and testbench

//  Issuing end of the PE ctrl interface. Stores up to DEPTH 11-bit PE ctrl words
//   (output[10:8]_op1[7:5]_op2[4:2]_opcode[1:0]) loaded over a cfg port.
//  On start, replays them in order, one word per cycle, into one PE ctrl input.

---
 rtl/pe_ctx_sequencer.sv | 117 +++++++++++
 tb/tb_pe_ctx_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pe_ctx_sequencer.sv
// Context sequencer that replays stored PE ctrl words, one per cycle, for a programmed number of passes.
// When it is not issuing it drives NOP, because the PE executes on every clock.
module pe_ctx_sequencer #(
    parameter int                CTRL_W = 11,
    parameter int                DEPTH  = 16,
    parameter int                AW     = $clog2(DEPTH),
    parameter int                LOOP_W = 8,
    parameter logic [CTRL_W-1:0] NOP    = {3'b111, 8'b0}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [CTRL_W-1:0] cfg_data,
    input  logic              start,
    input  logic [AW:0]       ctx_len,
    input  logic [LOOP_W-1:0] passes,
    input  logic              stall,
    input  logic              abort,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              ctrl_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_nx;
    logic [CTRL_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       pc;
    logic [AW:0]         len;
    logic [LOOP_W-1:0]   pass_cnt;

    logic                bad_start, is_last, pc_end;
    logic [AW-1:0]       npc, issue_pc;
    logic [LOOP_W-1:0]   npass;

    assign bad_start = (ctx_len == '0) || (ctx_len > (AW+1)'(DEPTH)) || (passes == '0);
    assign pc_end    = ({1'b0, pc} == len - (AW+1)'(1));
    assign is_last   = pc_end && (pass_cnt == LOOP_W'(1));
    assign npc       = pc_end ? '0 : pc + AW'(1);
    assign npass     = pc_end ? pass_cnt - LOOP_W'(1) : pass_cnt;
    // While ctrl_valid is high, pc names the word now on ctrl_out, so the next word follows it.
    // After a stall, pc already names the held word.
    assign issue_pc  = ctrl_valid ? npc : pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start && !bad_start) state_nx = RUN;
            RUN:  if (abort || (ctrl_valid && is_last)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state == IDLE) && !start;
        busy      = (state == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= NOP;
            pc         <= '0;
            len        <= '0;
            pass_cnt   <= '0;
            ctrl_out   <= NOP;
            ctrl_valid <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            ctrl_out   <= NOP;
            ctrl_valid <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid && cfg_ready) mem[cfg_addr] <= cfg_data;
                    if (start) begin
                        if (bad_start) begin
                            err <= 1'b1;
                        end else begin
                            len        <= ctx_len;
                            pass_cnt   <= passes;
                            pc         <= '0;
                            ctrl_out   <= mem[0];
                            ctrl_valid <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        // NOP defaults apply; the sequence is dropped
                    end else if (ctrl_valid && is_last) begin
                        done <= 1'b1;
                    end else begin
                        if (ctrl_valid) begin
                            pc       <= npc;
                            pass_cnt <= npass;
                        end
                        if (!stall) begin
                            ctrl_out   <= mem[issue_pc];
                            ctrl_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_ctx_sequencer.sv
// Directed bench for pe_ctx_sequencer: table of single-cycle vectors plus hand-written multi-cycle sequences.
module tb_pe_ctx_sequencer;
    localparam int CW = 11;
    localparam logic [CW-1:0] NOPW = {3'b111, 8'b0};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [3:0]    cfg_addr;
    logic [CW-1:0] cfg_data;
    logic          start;
    logic [4:0]    ctx_len;
    logic [7:0]    passes;
    logic          stall;
    logic          abort;
    logic [CW-1:0] ctrl_out;
    logic          ctrl_valid;
    logic          busy;
    logic          done;
    logic          err;

    int total = 0;
    int passed = 0;

    pe_ctx_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .ctx_len(ctx_len), .passes(passes), .stall(stall), .abort(abort),
        .ctrl_out(ctrl_out), .ctrl_valid(ctrl_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          cv;
        logic [3:0]    ca;
        logic [CW-1:0] cd;
        logic          st;
        logic [4:0]    len;
        logic [7:0]    ps;
        logic          sl;
        logic          ab;
        logic [CW-1:0] eo;
        logic          ev, eb, ed, ee;
    } vec_t;

    vec_t vt [28];

    function automatic vec_t mk(logic cv, logic [3:0] ca, logic [CW-1:0] cd, logic st,
                                logic [4:0] len, logic [7:0] ps, logic sl, logic ab,
                                logic [CW-1:0] eo, logic ev, logic eb, logic ed, logic ee);
        vec_t v;
        v.cv = cv; v.ca = ca; v.cd = cd; v.st = st; v.len = len; v.ps = ps; v.sl = sl; v.ab = ab;
        v.eo = eo; v.ev = ev; v.eb = eb; v.ed = ed; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        cfg_valid = 0; cfg_addr = 0; cfg_data = 0; start = 0;
        ctx_len = 0; passes = 0; stall = 0; abort = 0;
    endtask

    function automatic logic [CW-1:0] pat(input int i);
        return CW'(i * 37 + 5);
    endfunction

    initial begin
        rst_n = 0;
        idle_in();
        step(); step();
        chk("rst_ctrl_out", 32'(ctrl_out), 32'(NOPW));
        chk("rst_flags", {ctrl_valid, busy, done, err}, 4'b0000);
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        rst_n = 1;

        //           cv ca  cd      st len ps sl ab  eo      ev eb ed ee
        vt[0]  = mk(1, 0, 11'h501, 0, 0, 0, 0, 0, NOPW,    0, 0, 0, 0);
        vt[1]  = mk(1, 1, 11'h0A4, 0, 0, 0, 0, 0, NOPW,    0, 0, 0, 0);
        vt[2]  = mk(1, 2, 11'h10C, 0, 0, 0, 0, 0, NOPW,    0, 0, 0, 0);
        vt[3]  = mk(0, 0, 0,       1, 3, 1, 0, 0, 11'h501, 1, 1, 0, 0);
        vt[4]  = mk(0, 0, 0,       0, 0, 0, 0, 0, 11'h0A4, 1, 1, 0, 0);
        vt[5]  = mk(0, 0, 0,       0, 0, 0, 0, 0, 11'h10C, 1, 1, 0, 0);
        vt[6]  = mk(0, 0, 0,       0, 0, 0, 0, 0, NOPW,    0, 0, 1, 0);
        vt[7]  = mk(0, 0, 0,       0, 0, 0, 0, 0, NOPW,    0, 0, 0, 0);
        vt[8]  = mk(0, 0, 0,       1, 3, 1, 0, 0, 11'h501, 1, 1, 0, 0);
        vt[9]  = mk(0, 0, 0,       0, 0, 0, 1, 0, NOPW,    0, 1, 0, 0);
        vt[10] = mk(0, 0, 0,       0, 0, 0, 1, 0, NOPW,    0, 1, 0, 0);
        vt[11] = mk(0, 0, 0,       0, 0, 0, 0, 0, 11'h0A4, 1, 1, 0, 0);
        vt[12] = mk(0, 0, 0,       0, 0, 0, 0, 0, 11'h10C, 1, 1, 0, 0);
        vt[13] = mk(0, 0, 0,       0, 0, 0, 0, 0, NOPW,    0, 0, 1, 0);
        vt[14] = mk(0, 0, 0,       1, 0, 1, 0, 0, NOPW,    0, 0, 0, 1);
        vt[15] = mk(0, 0, 0,       1, 17, 1, 0, 0, NOPW,   0, 0, 0, 1);
        vt[16] = mk(0, 0, 0,       1, 3, 0, 0, 0, NOPW,    0, 0, 0, 1);
        vt[17] = mk(0, 0, 0,       0, 0, 0, 0, 0, NOPW,    0, 0, 0, 0);
        vt[18] = mk(1, 0, 11'h7FF, 1, 1, 1, 0, 0, 11'h501, 1, 1, 0, 0);
        vt[19] = mk(0, 0, 0,       0, 0, 0, 0, 0, NOPW,    0, 0, 1, 0);
        vt[20] = mk(0, 0, 0,       1, 1, 1, 0, 0, 11'h501, 1, 1, 0, 0);
        vt[21] = mk(0, 0, 0,       0, 0, 0, 0, 0, NOPW,    0, 0, 1, 0);
        vt[22] = mk(0, 0, 0,       1, 3, 3, 0, 0, 11'h501, 1, 1, 0, 0);
        vt[23] = mk(0, 0, 0,       0, 0, 0, 0, 0, 11'h0A4, 1, 1, 0, 0);
        vt[24] = mk(0, 0, 0,       0, 0, 0, 0, 0, 11'h10C, 1, 1, 0, 0);
        vt[25] = mk(0, 0, 0,       0, 0, 0, 0, 0, 11'h501, 1, 1, 0, 0);
        vt[26] = mk(0, 0, 0,       0, 0, 0, 1, 1, NOPW,    0, 0, 0, 0);
        vt[27] = mk(0, 0, 0,       0, 0, 0, 0, 0, NOPW,    0, 0, 0, 0);

        foreach (vt[i]) begin
            cfg_valid = vt[i].cv; cfg_addr = vt[i].ca; cfg_data = vt[i].cd;
            start = vt[i].st; ctx_len = vt[i].len; passes = vt[i].ps;
            stall = vt[i].sl; abort = vt[i].ab;
            step();
            chk($sformatf("vec%0d_ctrl_out", i), 32'(ctrl_out), 32'(vt[i].eo));
            chk($sformatf("vec%0d_flags", i), {ctrl_valid, busy, done, err},
                {vt[i].ev, vt[i].eb, vt[i].ed, vt[i].ee});
        end
        idle_in();

        // cfg_ready is low while start is asserted in IDLE and during RUN
        start = 1; ctx_len = 0; passes = 1; #1;
        chk("cfg_ready_start_idle", 32'(cfg_ready), 0);
        idle_in(); #1;
        chk("cfg_ready_idle", 32'(cfg_ready), 1);

        // full-depth, three-pass replay with wrap
        for (int i = 0; i < 16; i++) begin
            cfg_valid = 1; cfg_addr = 4'(i); cfg_data = pat(i);
            step();
        end
        idle_in();
        start = 1; ctx_len = 16; passes = 3;
        step();
        start = 0;
        chk("run_cfg_ready", 32'(cfg_ready), 0);
        begin
            int bad = 0;
            for (int k = 0; k < 48; k++) begin
                if (k > 0) step();
                if (ctrl_out !== pat(k % 16) || ctrl_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                    if (bad == 0) $display("FAIL loop16x3 word%0d: got %0h valid %0b want %0h", k, ctrl_out, ctrl_valid, pat(k % 16));
                    bad++;
                end
            end
            chk("loop16x3_bad_words", bad, 0);
        end
        step();
        chk("loop16x3_done", {ctrl_out, ctrl_valid, busy, done}, {NOPW, 3'b001});

        // single-entry, four passes
        start = 1; ctx_len = 1; passes = 4;
        step();
        start = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            chk($sformatf("len1_word%0d", k), {ctrl_out, ctrl_valid}, {pat(0), 1'b1});
        end
        step();
        chk("len1_done", {ctrl_out, ctrl_valid, busy, done}, {NOPW, 3'b001});

        // reset mid-run abandons the sequence and clears memory
        start = 1; ctx_len = 16; passes = 3;
        step();
        start = 0;
        step(); step();
        chk("prereset_busy", 32'(busy), 1);
        #2 rst_n = 0; #1;
        chk("midrst_ctrl_out", 32'(ctrl_out), 32'(NOPW));
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_cfg_ready", 32'(cfg_ready), 1);
        step();
        rst_n = 1;
        start = 1; ctx_len = 3; passes = 1;
        step();
        start = 0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            chk($sformatf("cleared_word%0d", k), {ctrl_out, ctrl_valid}, {NOPW, 1'b1});
        end
        step();
        chk("cleared_done", {ctrl_valid, busy, done}, 3'b001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
